alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, sequential successor to the 6-bit combinational ALU. Operands are latched on a start strobe. Single-cycle ops complete in one clock; MUL/DIV/MOD run an iterative W-cycle datapath. Each result carries a wrap-around result (z), a saturated result (zNoRing) and flags IOF/BAF/ZF, all held stable until the next start. Sits between the operand register file and the writeback mux of the Lola CPU datapath.

Parameters:
W, 6, operand/result width in bits (>=4)
CW, 4, op code width (fixed encoding below; must be 4)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
start  in  1  launch operation; sampled only when busy=0
x  in  W  operand A
y  in  W  operand B
op  in  CW  operation select, sampled with start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when z/zNoRing/flags become valid
z  out  W  ring (mod 2^W) result
zNoRing  out  W  saturated result
IOF  out  1  overflow: signed overflow for ADD/SUB/INC/DEC/NEG; unsigned overflow for MUL; divide-by-zero for DIV/MOD
BAF  out  1  unsigned carry (ADD/INC) or borrow (SUB/DEC/CMP); last bit shifted out (SHL/SHR/ASR); 0 otherwise
ZF  out  1  z == 0 (for CMP: x == y)

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; busy=0; done=0; z=0; zNoRing=0; IOF=BAF=ZF=0. Reset dominates start. Reset mid-operation aborts it; no done pulse.
- Op encoding:
  - 0000 ADD; 0001 SUB (x-y); 0010 AND; 0011 OR; 0100 XOR; 0101 NOT x
  - 0110 SHL x by y[log2W-1:0]; 0111 SHR logical; 1000 ASR
  - 1001 MUL unsigned; 1010 DIV unsigned (quotient); 1011 MOD unsigned (remainder)
  - 1100 INC x; 1101 DEC x; 1110 NEG x; 1111 CMP (x-y, flags only, z/zNoRing retain previous value)
- FSM states: IDLE, ITER, DONE.
  - IDLE + start, single-cycle op: result computed and registered; -> DONE. done=1 on the next cycle (latency 1).
  - IDLE + start, op in {MUL, DIV, MOD}: latch x, y; counter=W-1; busy=1; -> ITER.
  - ITER: one shift-add (MUL) or restoring subtract (DIV/MOD) step per cycle. At counter==0, write results -> DONE. done asserts W+1 cycles after start.
  - DONE: done=1 for exactly one cycle, busy=0; -> IDLE. A start in DONE is accepted as if in IDLE (back-to-back throughput).
- busy is 1 in ITER only. start while busy=1 is ignored, with no effect on operands or results.
- Arithmetic rules:
  - ADD/SUB/INC/DEC/NEG: z = low W bits. zNoRing clamps to signed limits on signed overflow (+ overflow -> 0 followed by 1s; - overflow -> 1 followed by 0s), otherwise zNoRing = z. NEG of most-negative: IOF=1, zNoRing=max positive.
  - MUL: z = low W bits of the 2W-bit product. IOF=1 if the high W bits are nonzero; then zNoRing = all ones.
  - DIV/MOD by y=0: z = all ones (DIV) or x (MOD); zNoRing = z; IOF=1; no early exit, latency unchanged.
  - Logic/shift ops: zNoRing = z, IOF=0. Shift amount >= W gives 0 (SHL/SHR) or sign fill (ASR); BAF = 0 for shift amount 0 or >= W.
- Outputs hold their values between done pulses. Changing x/y/op after start has no effect on the operation in flight.

Test Plan:
- W=6, rst held low 2 cycles with start=1 -> all outputs 0, busy=0, done never pulses; release -> still 0 until a start.
- ADD x=6'b011111, y=6'b000001 -> 1 cycle later done=1, z=6'b100000, zNoRing=6'b011111, IOF=1, BAF=0, ZF=0; SUB x=0, y=1 -> z=6'b111111, BAF=1, IOF=0.
- MUL x=9, y=9 -> busy high 6 cycles, done at start+7, z=6'b010001 (81 mod 64), zNoRing=6'b111111, IOF=1; MUL 3*5 -> z=15, IOF=0.
- DIV x=45, y=7 -> z=6; MOD -> z=3; DIV y=0 -> z=6'b111111, IOF=1, same 7-cycle latency.
- Start MUL, pulse start with ADD during ITER, assert rst on cycle 3 of ITER -> ADD ignored; after reset, outputs 0, no done pulse.
- Back-to-back: CMP x=5, y=5 (prior z=3) -> ZF=1, z stays 3; start ASR x=6'b100100, y=2 in the done cycle -> next cycle z=6'b111001, BAF=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential W-bit ALU for the Lola CPU datapath.
// Operands are captured on an accepted start. Single-cycle ops
// register their result right away. MUL/DIV/MOD iterate one bit
// per clock for W cycles. Results and flags hold until the next op.
module alu_seq #(
    parameter int W  = 6,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [CW-1:0] op,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  z,
    output logic [W-1:0]  zNoRing,
    output logic          IOF,
    output logic          BAF,
    output logic          ZF
);

    localparam int SW = $clog2(W);
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [SW-1:0] CNT_INIT = SW'(W-1);
    localparam logic [SW:0]   SH_LIMIT = (SW+1)'(W);

    localparam logic [CW-1:0] OP_ADD = 4'h0;
    localparam logic [CW-1:0] OP_SUB = 4'h1;
    localparam logic [CW-1:0] OP_AND = 4'h2;
    localparam logic [CW-1:0] OP_OR  = 4'h3;
    localparam logic [CW-1:0] OP_XOR = 4'h4;
    localparam logic [CW-1:0] OP_NOT = 4'h5;
    localparam logic [CW-1:0] OP_SHL = 4'h6;
    localparam logic [CW-1:0] OP_SHR = 4'h7;
    localparam logic [CW-1:0] OP_ASR = 4'h8;
    localparam logic [CW-1:0] OP_MUL = 4'h9;
    localparam logic [CW-1:0] OP_DIV = 4'hA;
    localparam logic [CW-1:0] OP_MOD = 4'hB;
    localparam logic [CW-1:0] OP_INC = 4'hC;
    localparam logic [CW-1:0] OP_DEC = 4'hD;
    localparam logic [CW-1:0] OP_NEG = 4'hE;
    localparam logic [CW-1:0] OP_CMP = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic            accept;
    logic            is_iter_op;

    logic [CW-1:0]   op_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [SW-1:0]   cnt_q;
    logic [2*W-1:0]  prod_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;

    logic [W-1:0]    z_q;
    logic [W-1:0]    zn_q;
    logic            iof_q;
    logic            baf_q;
    logic            zf_q;

    logic [SW-1:0]   sh;
    logic            sh_big;
    logic [W:0]      arith;
    logic [2*W-1:0]  sh_wide;
    logic            ovf;
    logic [W-1:0]    sc_z;
    logic [W-1:0]    sc_zn;
    logic            sc_iof;
    logic            sc_baf;
    logic            sc_zf;
    logic            sc_keep;

    logic [W:0]      mul_add;
    logic [2*W-1:0]  prod_d;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;
    logic [W-1:0]    it_z;
    logic [W-1:0]    it_zn;
    logic            it_iof;
    logic            it_zf;

    assign accept     = start && (state_q != ITER);
    assign is_iter_op = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    assign sh         = y[SW-1:0];
    assign sh_big     = ({1'b0, sh} >= SH_LIMIT);

    assign z       = z_q;
    assign zNoRing = zn_q;
    assign IOF     = iof_q;
    assign BAF     = baf_q;
    assign ZF      = zf_q;

    // State register; reset returns to IDLE and abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus busy/done decode; DONE accepts a new start like IDLE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = is_iter_op ? ITER : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle result from the live inputs, used only on an accepted start.
    always_comb begin
        arith   = '0;
        sh_wide = '0;
        ovf     = 1'b0;
        sc_baf  = 1'b0;
        sc_keep = 1'b0;
        case (op)
            OP_ADD: begin
                arith  = {1'b0, x} + {1'b0, y};
                sc_baf = arith[W];
                ovf    = (x[W-1] == y[W-1]) && (arith[W-1] != x[W-1]);
            end
            OP_SUB: begin
                arith  = {1'b0, x} - {1'b0, y};
                sc_baf = arith[W];
                ovf    = (x[W-1] != y[W-1]) && (arith[W-1] != x[W-1]);
            end
            OP_AND: arith = {1'b0, x & y};
            OP_OR:  arith = {1'b0, x | y};
            OP_XOR: arith = {1'b0, x ^ y};
            OP_NOT: arith = {1'b0, ~x};
            OP_SHL: begin
                sh_wide = {{W{1'b0}}, x} << sh;
                arith   = {1'b0, sh_wide[W-1:0]};
                sc_baf  = sh_wide[W];
                if (sh_big) begin
                    arith  = '0;
                    sc_baf = 1'b0;
                end
            end
            OP_SHR: begin
                sh_wide = {x, {W{1'b0}}} >> sh;
                arith   = {1'b0, sh_wide[2*W-1:W]};
                sc_baf  = sh_wide[W-1];
                if (sh_big) begin
                    arith  = '0;
                    sc_baf = 1'b0;
                end
            end
            OP_ASR: begin
                sh_wide = $signed({x, {W{1'b0}}}) >>> sh;
                arith   = {1'b0, sh_wide[2*W-1:W]};
                sc_baf  = sh_wide[W-1];
                if (sh_big) begin
                    arith  = {1'b0, {W{x[W-1]}}};
                    sc_baf = 1'b0;
                end
            end
            OP_INC: begin
                arith  = {1'b0, x} + (W+1)'(1);
                sc_baf = arith[W];
                ovf    = (x == MAX_POS);
            end
            OP_DEC: begin
                arith  = {1'b0, x} - (W+1)'(1);
                sc_baf = arith[W];
                ovf    = (x == MIN_NEG);
            end
            OP_NEG: begin
                arith = (W+1)'(0) - {1'b0, x};
                ovf   = (x == MIN_NEG);
            end
            OP_CMP: begin
                arith   = {1'b0, x} - {1'b0, y};
                sc_baf  = arith[W];
                sc_keep = 1'b1;
            end
            default: arith = '0;
        endcase
        sc_z   = arith[W-1:0];
        sc_iof = ovf;
        sc_zn  = ovf ? (sc_z[W-1] ? MAX_POS : MIN_NEG) : sc_z;
        sc_zf  = (op == OP_CMP) ? (x == y) : (sc_z == '0);
    end

    // One shift-add multiply step and one restoring divide step, plus final flags.
    always_comb begin
        mul_add   = prod_q[0] ? ({1'b0, prod_q[2*W-1:W]} + {1'b0, opa_q})
                              : {1'b0, prod_q[2*W-1:W]};
        prod_d    = {mul_add, prod_q[W-1:1]};
        div_shift = {rem_q, quo_q[W-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[W-1:0] - opb_q;
        rem_d     = div_ge ? div_diff : div_shift[W-1:0];
        quo_d     = {quo_q[W-2:0], div_ge};
        it_z      = '0;
        it_zn     = '0;
        it_iof    = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_z   = prod_d[W-1:0];
                it_iof = (prod_d[2*W-1:W] != '0);
                it_zn  = it_iof ? ALL_ONES : it_z;
            end
            OP_DIV: begin
                it_z   = quo_d;
                it_iof = (opb_q == '0);
                it_zn  = it_z;
            end
            OP_MOD: begin
                it_z   = rem_d;
                it_iof = (opb_q == '0);
                it_zn  = it_z;
            end
            default: it_z = '0;
        endcase
        it_zf = (it_z == '0);
    end

    // Operand capture on start and the iteration registers stepping in ITER.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (accept) begin
            op_q   <= op;
            opa_q  <= x;
            opb_q  <= y;
            cnt_q  <= CNT_INIT;
            prod_q <= {{W{1'b0}}, y};
            rem_q  <= '0;
            quo_q  <= x;
        end else if (state_q == ITER) begin
            cnt_q  <= cnt_q - SW'(1);
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // Result/flag registers; CMP leaves z and zNoRing untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z_q   <= '0;
            zn_q  <= '0;
            iof_q <= 1'b0;
            baf_q <= 1'b0;
            zf_q  <= 1'b0;
        end else if (accept && !is_iter_op) begin
            if (!sc_keep) begin
                z_q  <= sc_z;
                zn_q <= sc_zn;
            end
            iof_q <= sc_iof;
            baf_q <= sc_baf;
            zf_q  <= sc_zf;
        end else if ((state_q == ITER) && (cnt_q == '0)) begin
            z_q   <= it_z;
            zn_q  <= it_zn;
            iof_q <= it_iof;
            baf_q <= 1'b0;
            zf_q  <= it_zf;
        end
    end

endmodule
